fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Parametrised single-clock FIFO. Successor to the dual-clock FIFO model in the primitives library.
- Adds:
  - true full/empty flags and an occupancy count;
  - programmable almost-full/almost-empty thresholds;
  - selectable normal or show-ahead read mode;
  - overflow/underflow error pulses;
  - a synchronous clear.
- Sits in the primitives/fifo library as the default buffering element between same-clock streaming stages.

Parameters:
- DATA_WIDTH, 16, width of data_in/data_out.
- ADDR_BITS, 10, pointer width. Depth is exactly 2**ADDR_BITS.
- FIFO_DEPTH, 1024, must equal 2**ADDR_BITS. A mismatch is an elaboration error.
- SHOW_AHEAD, 0:
  - 0 = normal mode: data appears 1 cycle after rd_req.
  - 1 = show-ahead mode: head word is presented while not empty.
- AFULL_THRESH, FIFO_DEPTH-4, almost_full asserts when usedw >= this value.
- AEMPTY_THRESH, 4, almost_empty asserts when usedw <= this value.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global enable. When 0, wr_req/rd_req are ignored and state holds.
- clr  in  1  synchronous flush. Pointers and count go to 0; memory contents are not cleared.
- wr_req  in  1  write request.
- rd_req  in  1  read request (pop).
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  usedw == FIFO_DEPTH.
- empty  out  1  usedw == 0.
- almost_full  out  1  usedw >= AFULL_THRESH.
- almost_empty  out  1  usedw <= AEMPTY_THRESH.
- usedw  out  ADDR_BITS+1  occupancy, 0..FIFO_DEPTH.
- overflow  out  1  1-cycle pulse: write rejected because full.
- underflow  out  1  1-cycle pulse: read rejected because empty.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, usedw = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0, underflow=0, data_out=0.
  - Memory contents are not reset.
- Reset mid-operation discards all contents immediately. The first write after release is read back first.
- Acceptance, evaluated with en=1 and clr=0:
  - rd_ok = rd_req & !empty.
  - wr_ok = wr_req & (!full | rd_ok). A write to a full FIFO is accepted only with a simultaneous accepted read.
  - Empty FIFO with rd_req & wr_req: write accepted, read rejected, underflow pulses.
- Pointers:
  - ADDR_BITS wide; wrap naturally from FIFO_DEPTH-1 to 0.
  - wr_ok: mem[wr_ptr] <= data_in, then wr_ptr+1.
  - rd_ok: rd_ptr+1.
- usedw: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds FIFO_DEPTH or goes below 0.
- Flags (full, empty, almost_*) are registered and derived from the next value of usedw, so they are valid in the same cycle as the updated usedw.
- Normal mode (SHOW_AHEAD=0):
  - On rd_ok, data_out <= mem[rd_ptr], valid the cycle after the request.
  - data_out holds its value otherwise, including on rejected reads.
- Show-ahead mode (SHOW_AHEAD=1):
  - data_out = mem[rd_ptr] whenever !empty; rd_req consumes it.
  - Data written into an empty FIFO is visible on data_out 1 cycle after the write (once empty deasserts).
  - data_out is don't-care while empty. The bench must not check it.
- overflow = en & !clr & wr_req & full & !rd_ok, registered, 1-cycle pulse.
- underflow = en & !clr & rd_req & empty, registered, 1-cycle pulse.
- clr:
  - Takes priority over wr_req/rd_req in the same cycle.
  - Next cycle: usedw=0, empty=1, full=0, no error pulses.
  - data_out holds its value in normal mode.
- en=0: no pointer, count, memory or flag change. overflow/underflow = 0.
- Thresholds: AFULL_THRESH and AEMPTY_THRESH are compared against the full ADDR_BITS+1 usedw. Thresholds outside 0..FIFO_DEPTH simply leave the flag constant.

Decomposition:
- Package fifo_pkg holds:
  - depth/width helper function (clog2);
  - mode constants FIFO_MODE_NORMAL=0 and FIFO_MODE_SHOWAHEAD=1.
- One sub-module, fifo_ram: simple dual-port RAM.
  - One write port: we, waddr, wdata.
  - One read port: raddr, plus a registered or combinational rdata selected by a parameter.
  - Keeps memory inferable.
- Control logic (pointers, count, flags, errors) stays in fifo_sync.

Test Plan:
- Reset and basic order:
  - Stimulus: rst_n low, release; write 0x0001..0x0004 (normal mode), then read 4 times.
  - Response: data_out = 0x0001..0x0004, each 1 cycle after its rd_req. usedw goes 4→0; empty reasserts on the last read.
- Fill and overflow (ADDR_BITS=3, depth 8):
  - Stimulus: 9 writes.
  - Response: full=1 after the 8th write, overflow pulses on the 9th, usedw=8.
  - Stimulus: simultaneous rd+wr while full.
  - Response: both accepted, usedw stays 8, no overflow.
- Underflow and empty corner:
  - Stimulus: rd_req on empty.
  - Response: underflow pulses, usedw=0.
  - Stimulus: rd_req+wr_req on empty.
  - Response: write only accepted, usedw=1, underflow pulses.
- Wrap-around (depth 8):
  - Stimulus: 20 write/read pairs with usedw oscillating 0..3.
  - Response: data order preserved across pointer wrap 7→0.
- Show-ahead (SHOW_AHEAD=1):
  - Stimulus: write 0xAAAA into empty.
  - Response: next cycle empty=0, data_out=0xAAAA with no rd_req.
  - Stimulus: rd_req.
  - Response: empty=1 next cycle.
- Thresholds/clr/en (depth 8, AFULL=6, AEMPTY=2):
  - almost_empty drops at usedw=3; almost_full rises at usedw=6.
  - en=0 with requests: no change.
  - clr with wr_req high: usedw=0, empty=1 next cycle.
  - rst_n low at usedw=5: immediately usedw=0, empty=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the primitives/fifo library.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_NORMAL    = 0;
  localparam int unsigned FIFO_MODE_SHOWAHEAD = 1;

  // Ceiling log2; used to cross-check depth against pointer width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with
// selectable registered or combinational read data.
module fifo_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 10,
  parameter bit          REG_RDATA  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is left unreset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register reads the old word when read and write hit the same address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = REG_RDATA ? rdata_q : mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// normal/show-ahead read modes, error pulses and synchronous clear.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_BITS     = 10,
  parameter int unsigned FIFO_DEPTH    = 1024,
  parameter int unsigned SHOW_AHEAD    = FIFO_MODE_NORMAL,
  parameter int          AFULL_THRESH  = int'(FIFO_DEPTH) - 4,
  parameter int          AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = ADDR_BITS + 1;

  if (FIFO_DEPTH != 2 ** ADDR_BITS || clog2(FIFO_DEPTH) != ADDR_BITS) begin : g_bad_depth
    $error("fifo_sync: FIFO_DEPTH must equal 2**ADDR_BITS");
  end

  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]        usedw_nxt;
  logic                 active, rd_ok, wr_ok, overflow_nxt, underflow_nxt;

  // Acceptance and next-state; clear wins over requests, en=0 freezes all.
  always_comb begin
    active        = en & ~clr;
    rd_ok         = active & rd_req & ~empty;
    wr_ok         = active & wr_req & (~full | rd_ok);
    overflow_nxt  = active & wr_req & full & ~rd_ok;
    underflow_nxt = active & rd_req & empty;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    usedw_nxt     = usedw;
    if (en && clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      usedw_nxt  = '0;
    end else begin
      if (wr_ok) wr_ptr_nxt = wr_ptr + ADDR_BITS'(1);
      if (rd_ok) rd_ptr_nxt = rd_ptr + ADDR_BITS'(1);
      case ({wr_ok, rd_ok})
        2'b10:   usedw_nxt = usedw + CW'(1);
        2'b01:   usedw_nxt = usedw - CW'(1);
        default: usedw_nxt = usedw;
      endcase
    end
  end

  // Flags are registered from the next count so they track usedw exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      usedw        <= usedw_nxt;
      full         <= (usedw_nxt == CW'(FIFO_DEPTH));
      empty        <= (usedw_nxt == '0);
      almost_full  <= (int'(usedw_nxt) >= AFULL_THRESH);
      almost_empty <= (int'(usedw_nxt) <= AEMPTY_THRESH);
      overflow     <= overflow_nxt;
      underflow    <= underflow_nxt;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS),
    .REG_RDATA  (SHOW_AHEAD == FIFO_MODE_NORMAL)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Scoreboard bench for fifo_sync: normal-mode and show-ahead instances, depth 8.
module tb_fifo_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1, clr = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  usedw;

  logic        sa_wr = 1'b0, sa_rd = 1'b0;
  logic [15:0] sa_din = '0;
  logic [15:0] sa_dout;
  logic        sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_unf;
  logic [3:0]  sa_usedw;

  int checks = 0;
  int errors = 0;

  logic [15:0] q[$];
  logic [15:0] sa_q[$];
  logic [15:0] exp_dout = '0;
  bit          exp_ovf, exp_unf;

  always #5 clk = ~clk;

  fifo_sync #(.DATA_WIDTH(16), .ADDR_BITS(3), .FIFO_DEPTH(8), .SHOW_AHEAD(0),
              .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_norm (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .wr_req(wr_req), .rd_req(rd_req),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .usedw(usedw),
    .overflow(overflow), .underflow(underflow));

  fifo_sync #(.DATA_WIDTH(16), .ADDR_BITS(3), .FIFO_DEPTH(8), .SHOW_AHEAD(1),
              .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_sa (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .wr_req(sa_wr), .rd_req(sa_rd),
    .data_in(sa_din), .data_out(sa_dout), .full(sa_full), .empty(sa_empty),
    .almost_full(sa_af), .almost_empty(sa_ae), .usedw(sa_usedw),
    .overflow(sa_ovf), .underflow(sa_unf));

  // Drive one cycle on the normal instance (called at negedge) and advance the model.
  task automatic step(input bit wr, input bit rd, input logic [15:0] din,
                      input bit e, input bit c);
    bit rd_ok, wr_ok;
    int cnt;
    cnt     = q.size();
    rd_ok   = e && !c && rd && cnt > 0;
    wr_ok   = e && !c && wr && (cnt < 8 || rd_ok);
    exp_ovf = e && !c && wr && cnt == 8 && !rd_ok;
    exp_unf = e && !c && rd && cnt == 0;
    if (e && c) q.delete();
    else begin
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(din);
    end
    en = e; clr = c; wr_req = wr; rd_req = rd; data_in = din;
    @(posedge clk);
    @(negedge clk);
    en = 1'b1; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL reset_usedw got %0d want 0", usedw); end
    checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin errors++;
      $display("FAIL reset_flags got %b want 1100", {empty, almost_empty, full, almost_full}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++;
      $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", data_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_order;
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
    checks++; if (usedw !== 4'd4) begin errors++; $display("FAIL order_usedw got %0d want 4", usedw); end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
      checks++; if (data_out !== 16'(i)) begin errors++; $display("FAIL order_dout got %h want %h", data_out, 16'(i)); end
      checks++; if (usedw !== 4'(4 - i)) begin errors++; $display("FAIL order_cnt got %0d want %0d", usedw, 4 - i); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b want 1", empty); end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b0, 16'h0010 + 16'(i), 1'b1, 1'b0);
      if (i == 7) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf8 got %b want 0", overflow); end
      end
    end
    checks++; if (overflow !== exp_ovf || !exp_ovf) begin errors++; $display("FAIL fill_ovf9 got %b want 1", overflow); end
    checks++; if (usedw !== 4'd8) begin errors++; $display("FAIL fill_usedw got %0d want 8", usedw); end
    step(1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0);
    checks++; if (usedw !== 4'd8) begin errors++; $display("FAIL full_rw_usedw got %0d want 8", usedw); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got %b want 0", overflow); end
    checks++; if (data_out !== 16'h0010) begin errors++; $display("FAIL full_rw_dout got %h want 0010", data_out); end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
      checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL drain_dout got %h want %h", data_out, exp_dout); end
    end
    checks++; if (exp_dout !== 16'h00AA) begin errors++; $display("FAIL drain_last got %h want 00aa", exp_dout); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_underflow;
    logic [15:0] held;
    held = exp_dout;
    step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse got %b want 1", underflow); end
    checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL unf_usedw got %0d want 0", usedw); end
    checks++; if (data_out !== held) begin errors++; $display("FAIL unf_hold got %h want %h", data_out, held); end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b want 0", underflow); end
    step(1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    checks++; if (usedw !== 4'd1) begin errors++; $display("FAIL rw_empty_usedw got %0d want 1", usedw); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL rw_empty_unf got %b want 1", underflow); end
    step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    checks++; if (data_out !== 16'h5A5A) begin errors++; $display("FAIL rw_empty_dout got %h want 5a5a", data_out); end
  endtask

  task automatic test_wrap;
    int wn;
    wn = 0;
    for (int i = 0; i < 40; i++) begin
      if (((i / 3) % 2) == 0) begin
        step(1'b1, 1'b0, 16'hC000 + 16'(wn), 1'b1, 1'b0);
        wn++;
      end else begin
        step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
        checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL wrap_dout got %h want %h", data_out, exp_dout); end
      end
      checks++; if (usedw !== 4'(q.size())) begin errors++; $display("FAIL wrap_usedw got %0d want %0d", usedw, q.size()); end
    end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
      checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL wrap_tail got %h want %h", data_out, exp_dout); end
    end
  endtask

  task automatic test_thresholds_clr_en;
    logic [15:0] held;
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b0, 16'h7000 + 16'(k), 1'b1, 1'b0);
      checks++; if (almost_empty !== (k <= 2)) begin errors++; $display("FAIL ae_at_%0d got %b want %b", k, almost_empty, k <= 2); end
      checks++; if (almost_full !== (k >= 6)) begin errors++; $display("FAIL af_at_%0d got %b want %b", k, almost_full, k >= 6); end
    end
    held = exp_dout;
    step(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    checks++; if (usedw !== 4'd7) begin errors++; $display("FAIL en0_usedw got %0d want 7", usedw); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL en0_err got %b want 00", {overflow, underflow}); end
    checks++; if (data_out !== held) begin errors++; $display("FAIL en0_dout got %h want %h", data_out, held); end
    step(1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1);
    checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL clr_usedw got %0d want 0", usedw); end
    checks++; if ({empty, full, almost_full} !== 3'b100) begin errors++; $display("FAIL clr_flags got %b want 100", {empty, full, almost_full}); end
    checks++; if (data_out !== held) begin errors++; $display("FAIL clr_dout got %h want %h", data_out, held); end
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 16'h3300 + 16'(k), 1'b1, 1'b0);
    checks++; if (usedw !== 4'd5) begin errors++; $display("FAIL prerst_usedw got %0d want 5", usedw); end
    rst_n = 1'b0;
    #1;
    checks++; if (usedw !== 4'd0) begin errors++; $display("FAIL async_rst_usedw got %0d want 0", usedw); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL async_rst_empty got %b want 1", empty); end
    q.delete();
    exp_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL postrst_dout got %h want 1234", data_out); end
  endtask

  task automatic sa_cycle(input bit wr, input bit rd, input logic [15:0] din);
    if (rd && sa_q.size() > 0) void'(sa_q.pop_front());
    if (wr) sa_q.push_back(din);
    sa_wr = wr; sa_rd = rd; sa_din = din;
    @(posedge clk);
    @(negedge clk);
    sa_wr = 1'b0; sa_rd = 1'b0;
  endtask

  task automatic test_show_ahead;
    sa_cycle(1'b1, 1'b0, 16'hAAAA);
    checks++; if (sa_empty !== 1'b0) begin errors++; $display("FAIL sa_empty_after_wr got %b want 0", sa_empty); end
    checks++; if (sa_dout !== 16'hAAAA) begin errors++; $display("FAIL sa_head got %h want aaaa", sa_dout); end
    sa_cycle(1'b0, 1'b1, 16'h0);
    checks++; if (sa_empty !== 1'b1) begin errors++; $display("FAIL sa_empty_after_rd got %b want 1", sa_empty); end
    sa_cycle(1'b1, 1'b0, 16'hB001);
    sa_cycle(1'b1, 1'b0, 16'hB002);
    checks++; if (sa_dout !== sa_q[0]) begin errors++; $display("FAIL sa_head1 got %h want %h", sa_dout, sa_q[0]); end
    sa_cycle(1'b0, 1'b1, 16'h0);
    checks++; if (sa_dout !== sa_q[0]) begin errors++; $display("FAIL sa_head2 got %h want %h", sa_dout, sa_q[0]); end
    checks++; if (sa_usedw !== 4'd1) begin errors++; $display("FAIL sa_usedw got %0d want 1", sa_usedw); end
    sa_cycle(1'b0, 1'b1, 16'h0);
    checks++; if ({sa_empty, sa_ae, sa_full, sa_af, sa_ovf, sa_unf} !== 6'b110000) begin errors++;
      $display("FAIL sa_final_flags got %b want 110000", {sa_empty, sa_ae, sa_full, sa_af, sa_ovf, sa_unf}); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_fill_overflow();
    test_underflow();
    test_wrap();
    test_thresholds_clr_en();
    test_show_ahead();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
